// File: rtl/rom_stream_sink.sv
// rom_stream_sink: packs the loader byte stream into 16-bit words
// and writes them to cartridge ROM through a small word FIFO.
module rom_stream_sink #(
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        din,
    input  logic              din_valid,
    input  logic              loading,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count,
    output logic [ADDR_W-1:0] rom_mask,
    output logic [15:0]       checksum,
    output logic              overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_RECEIVE, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [15:0]       sum_q, sum_d;
    logic [ADDR_W-1:0] mask_q, mask_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        hold_q, hold_d;
    logic [ADDR_W-2:0] waddr_q, waddr_d;

    logic [ADDR_W-2:0] fa_q [FIFO_DEPTH];
    logic [15:0]       fd_q [FIFO_DEPTH];
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]       lvl_q, lvl_d;

    logic              take, want_push, push, pop, full;
    logic [ADDR_W-2:0] push_addr;
    logic [15:0]       push_data;
    logic [ADDR_W-1:0] smear;

    assign mem_req   = (lvl_q != '0);
    assign pop       = mem_req && mem_ack;
    assign full      = (lvl_q == (PW+1)'(FIFO_DEPTH)) && !pop;
    assign push      = want_push && !full;
    assign mem_addr  = mem_req ? fa_q[rp_q] : '0;
    assign mem_wdata = mem_req ? fd_q[rp_q] : '0;

    assign busy       = (state_q == S_RECEIVE) ||
                        (state_q == S_FLUSH) ||
                        (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign byte_count = cnt_q;
    assign checksum   = sum_q;
    assign rom_mask   = mask_q;
    assign overflow   = ovf_q;

    // Round byte_count-1 up to an all-ones mask.
    always_comb begin
        smear = ADDR_W'(cnt_q - (ADDR_W+1)'(1));
        for (int s = 1; s < ADDR_W; s = s * 2) begin
            smear = smear | (smear >> s);
        end
        if (cnt_q <= (ADDR_W+1)'(1)) begin
            smear = '0;
        end
    end

    // Next-state, byte packing and word push decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        mask_d    = mask_q;
        ovf_d     = ovf_q;
        hold_d    = hold_q;
        waddr_d   = waddr_q;
        take      = 1'b0;
        want_push = 1'b0;
        push_data = '0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (loading) begin
                    state_d = S_RECEIVE;
                    cnt_d   = '0;
                    sum_d   = '0;
                    mask_d  = '0;
                    ovf_d   = 1'b0;
                    hold_d  = '0;
                    waddr_d = '0;
                    take    = din_valid;
                end
            end
            S_RECEIVE: begin
                take = din_valid;
                if (!loading) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                mask_d  = smear;
                state_d = S_DRAIN;
                if (cnt_q[0]) begin
                    want_push = 1'b1;
                    push_data = {8'hFF, hold_q};
                end
            end
            S_DRAIN: begin
                if (!mem_req) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (take) begin
            if (cnt_d[ADDR_W]) begin
                ovf_d = 1'b1;
            end else begin
                if (cnt_d[0]) begin
                    want_push = 1'b1;
                    push_data = {din, hold_d};
                end else begin
                    hold_d = din;
                end
                cnt_d = cnt_d + (ADDR_W+1)'(1);
                sum_d = sum_d + 16'(din);
            end
        end
        push_addr = waddr_d;
        if (want_push) begin
            waddr_d = waddr_d + (ADDR_W-1)'(1);
            if (full) begin
                ovf_d = 1'b1;
            end
        end
    end

    // FIFO pointer and fill-level bookkeeping.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        lvl_d = lvl_q;
        if (push) begin
            wp_d = wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = rp_q + PW'(1);
        end
        if (push && !pop) begin
            lvl_d = lvl_q + (PW+1)'(1);
        end else if (!push && pop) begin
            lvl_d = lvl_q - (PW+1)'(1);
        end
    end

    // FIFO storage; contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fa_q[wp_q] <= push_addr;
            fd_q[wp_q] <= push_data;
        end
    end

    // FSM, counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            mask_q  <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= '0;
            waddr_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            lvl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
            waddr_q <= waddr_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            lvl_q   <= lvl_d;
        end
    end
endmodule

// File: tb/tb_rom_stream_sink.sv
// tb_rom_stream_sink: directed load vectors against rom_stream_sink
// (12-bit address space so the size boundary is reachable).
module tb_rom_stream_sink;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    din;
    logic          din_valid;
    logic          loading;
    logic          mem_req;
    logic [AW-2:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_ack;
    logic          busy;
    logic          done;
    logic [AW:0]   byte_count;
    logic [AW-1:0] rom_mask;
    logic [15:0]   checksum;
    logic          overflow;

    always #5 clk = ~clk;

    rom_stream_sink #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .din(din),
        .din_valid(din_valid), .loading(loading),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .byte_count(byte_count),
        .rom_mask(rom_mask), .checksum(checksum),
        .overflow(overflow)
    );

    typedef struct {
        logic [7:0]    first;
        int            n;
        int            gap;
        int            ack_low;
        logic [AW:0]   e_cnt;
        logic [15:0]   e_sum;
        logic [AW-1:0] e_mask;
        logic          e_ovf;
        int            e_words;
    } vec_t;

    typedef struct {
        logic [AW-2:0] a;
        logic [15:0]   d;
    } wr_t;

    vec_t tab[7];
    wr_t  log_q[$];
    int   tests = 0;
    int   fails = 0;
    int   stab_err = 0;
    logic          p_req = 1'b0;
    logic          p_ack = 1'b0;
    logic [AW-2:0] p_addr = '0;
    logic [15:0]   p_data = '0;

    // Log accepted writes; a stalled request must hold its entry.
    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            log_q.push_back(wr_t'{mem_addr, mem_wdata});
        end
        if (p_req && !p_ack && mem_req &&
            (mem_addr != p_addr || mem_wdata != p_data)) begin
            stab_err <= stab_err + 1;
        end
        p_req  <= mem_req;
        p_ack  <= mem_ack;
        p_addr <= mem_addr;
        p_data <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int budget;
        int nb;
        int bad_w;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [31:0] ev;
        logic [31:0] av;
        cyc = 0;
        log_q.delete();
        for (int i = 0; i < v.n; i++) begin
            loading   = 1'b1;
            din_valid = 1'b1;
            din       = v.first + 8'(i);
            mem_ack   = (cyc >= v.ack_low);
            step();
            cyc++;
            if (i == 0) begin
                chk($sformatf("v%0d busy_not_done", idx),
                    {30'd0, busy, done}, 32'h2);
            end
            din_valid = 1'b0;
            for (int g = 0; g < v.gap; g++) begin
                mem_ack = (cyc >= v.ack_low);
                step();
                cyc++;
            end
        end
        loading   = 1'b0;
        din_valid = 1'b0;
        budget    = 0;
        while (!done && budget < 6000) begin
            mem_ack = (cyc >= v.ack_low);
            step();
            cyc++;
            budget++;
        end
        chk($sformatf("v%0d done", idx), done, 1);
        chk($sformatf("v%0d byte_count", idx), byte_count, v.e_cnt);
        chk($sformatf("v%0d checksum", idx), checksum, v.e_sum);
        chk($sformatf("v%0d rom_mask", idx), rom_mask, v.e_mask);
        chk($sformatf("v%0d overflow", idx), overflow, v.e_ovf);
        chk($sformatf("v%0d nwrites", idx), log_q.size(), v.e_words);
        nb    = (v.n > (1 << AW)) ? (1 << AW) : v.n;
        bad_w = -1;
        ev    = '0;
        av    = '0;
        for (int w = 0; w < v.e_words && w < log_q.size(); w++) begin
            lo = v.first + 8'(2 * w);
            hi = (2 * w + 1 < nb) ? v.first + 8'(2 * w + 1) : 8'hFF;
            if (bad_w < 0 && (log_q[w].a !== (AW-1)'(w) ||
                              log_q[w].d !== {hi, lo})) begin
                bad_w = w;
                ev = {5'd0, (AW-1)'(w), hi, lo};
                av = {5'd0, log_q[w].a, log_q[w].d};
            end
        end
        tests++;
        if (bad_w >= 0) begin
            fails++;
            $display("FAIL v%0d write[%0d]: got %0h expected %0h",
                     idx, bad_w, av, ev);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tab[0] = '{8'h01, 4,    0,  0,   13'd4,    16'h000A, 12'h003, 1'b0, 2};
        tab[1] = '{8'h01, 3,    0,  0,   13'd3,    16'h0006, 12'h003, 1'b0, 2};
        tab[2] = '{8'h01, 16,   0,  5,   13'd16,   16'h0088, 12'h00F, 1'b0, 8};
        tab[3] = '{8'h01, 20,   15, 330, 13'd20,   16'h00D2, 12'h01F, 1'b1, 4};
        tab[4] = '{8'h00, 4096, 0,  0,   13'd4096, 16'hF800, 12'hFFF, 1'b0, 2048};
        tab[5] = '{8'h01, 4097, 0,  0,   13'd4096, 16'hF800, 12'hFFF, 1'b1, 2048};
        tab[6] = '{8'hAA, 2,    0,  0,   13'd2,    16'h0155, 12'h001, 1'b0, 1};

        reset     = 1'b1;
        loading   = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        mem_ack   = 1'b0;
        repeat (3) step();
        chk("rst mem_req", mem_req, 0);
        chk("rst busy_done", {busy, done}, 0);
        chk("rst byte_count", byte_count, 0);
        chk("rst checksum", checksum, 0);
        chk("rst rom_mask", rom_mask, 0);
        chk("rst overflow", overflow, 0);
        reset = 1'b0;
        step();

        for (int k = 0; k < 7; k++) begin
            run_vec(tab[k], k);
        end

        din_valid = 1'b1;
        din       = 8'h77;
        repeat (2) step();
        din_valid = 1'b0;
        chk("done ignores din", {byte_count, done}, {13'd2, 1'b1});

        reset = 1'b1;
        step();
        reset   = 1'b0;
        mem_ack = 1'b0;
        loading = 1'b1;
        din_valid = 1'b1;
        din = 8'hA0;
        step();
        din = 8'hA1;
        step();
        chk("first word req", {mem_req, 5'd0, mem_addr, mem_wdata},
            {1'b1, 5'd0, 11'd0, 16'hA1A0});
        for (int i = 2; i < 6; i++) begin
            din = 8'hA0 + 8'(i);
            step();
        end
        chk("mid count", byte_count, 6);
        reset     = 1'b1;
        loading   = 1'b0;
        din_valid = 1'b0;
        step();
        chk("midrst mem_req", mem_req, 0);
        chk("midrst port", {mem_addr, mem_wdata}, 0);
        chk("midrst state", {busy, done, overflow}, 0);
        chk("midrst counters", {byte_count, checksum, rom_mask}, 0);
        reset     = 1'b0;
        din_valid = 1'b1;
        din       = 8'h55;
        repeat (2) step();
        din_valid = 1'b0;
        chk("idle ignores din", {byte_count, busy}, 0);
        run_vec('{8'h11, 2, 0, 0, 13'd2, 16'h0023, 12'h001, 1'b0, 1}, 7);

        step();
        chk("req hold stable", stab_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
